fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls characters from a registered-output sync FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module fifo_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IW = ($clog2(DATA_WIDTH) > 3) ? $clog2(DATA_WIDTH) : 3;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  bit_end;
`ifdef UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   assign bit_end = (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // tx_d is the line level for the state being entered, so tx stays a flop output
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      fifo_r_en = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            tx_d  = 1'b1;
            if (!fifo_empty) begin
               // gated by rst so no read strobe leaks out while held in reset
               fifo_r_en = rst;
               state_d   = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_data;
`endif
            cnt_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_MAX) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               tx_d    = 1'b1;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               tx_d    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized self-checking bench for fifo_uart_tx against a frame-level line model.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
   localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = DW + 3;
`else
   localparam int NBITS = DW + 2;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_r_en, tx, busy, frame_done;

   logic [7:0]    mem [0:255];
   int unsigned   wr_ptr = 0;
   int unsigned   rd_ptr = 0;
   int unsigned   ren_cnt = 0;
   int            checks = 0;
   int            errors = 0;
   byte unsigned  exp_q[$];

   fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_r_en(fifo_r_en), .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // upstream sync FIFO: registered read data, empty flag from pointers
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_r_en) begin
         fifo_data <= mem[rd_ptr % 256];
         rd_ptr    <= rd_ptr + 1;
         ren_cnt   <= ren_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic push_byte(input byte unsigned b);
      mem[wr_ptr % 256] = b;
      wr_ptr = wr_ptr + 1;
      exp_q.push_back(b);
   endtask

   // line level of bit k of a frame: start, data LSB first, [even parity], stop
   function automatic logic exp_bit(input byte unsigned b, input int k);
      if (k == 0) return 1'b0;
      if (k <= DW) return logic'((b >> (k - 1)) & 1);
      if (NBITS == DW + 3 && k == DW + 1) return logic'($countones(b) % 2);
      return 1'b1;
   endfunction

   task automatic wait_ren(output bit found);
      found = 0;
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge clk);
         if (fifo_r_en) found = 1;
      end
      if (!found) check("ren_timeout", 0, 1);
   endtask

   // expects n back-to-back frames for the oldest n queued bytes
   task automatic check_frames(input int n);
      bit found;
      byte unsigned b;
      for (int f = 0; f < n; f++) begin
         b = exp_q.pop_front();
         if (f == 0) begin
            wait_ren(found);
            if (!found) return;
         end else begin
            @(negedge clk);
            check("gap_ren", fifo_r_en, 1);
         end
         check("idle_tx", tx, 1);
         check("idle_busy", busy, 0);
         for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            check("pre_tx", tx, 1);
            check("pre_busy", busy, 1);
            check("pre_ren", fifo_r_en, 0);
         end
         for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
               @(negedge clk);
               check($sformatf("bit%0d_b%02h", k, b), tx, exp_bit(b, k));
               check("frame_done", frame_done, (k == NBITS - 1 && c == CPB - 1));
               check("frame_ren", fifo_r_en, 0);
            end
         end
      end
      @(negedge clk);
      check("end_busy", busy, 0);
      check("end_tx", tx, 1);
      check("end_ren", fifo_r_en, 0);
   endtask

   initial begin
      int unsigned bad;
      int unsigned c0;
      int n;
      bit found;

      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ren", fifo_r_en, 0);
      check("rst_done", frame_done, 0);
      @(posedge clk); #1 rst = 1'b1;

      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (fifo_r_en || !tx || busy || frame_done) bad++;
      end
      check("idle200", bad, 0);
      check("idle200_ren", ren_cnt, 0);

      @(posedge clk); #1 push_byte(8'hA5);
      check_frames(1);

      c0 = ren_cnt;
      @(posedge clk); #1 push_byte(8'h00); push_byte(8'hFF);
      check_frames(2);
      check("two_ren", ren_cnt - c0, 2);

      @(posedge clk); #1 push_byte(8'h07);
      check_frames(1);

      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(1, 4));
         c0 = ren_cnt;
         @(posedge clk); #1;
         for (int i = 0; i < n; i++) push_byte(byte'($urandom_range(0, 255)));
         check_frames(n);
         check("burst_ren", ren_cnt - c0, n);
         repeat ($urandom_range(0, 8)) begin
            @(negedge clk);
            check("gap_idle_tx", tx, 1);
         end
      end

      // reset in the middle of data bit 3 of 0x55
      @(posedge clk); #1 push_byte(8'h55);
      wait_ren(found);
      if (found) begin
         repeat (20) @(negedge clk);
         check("mid_bit3", tx, 0);
         check("mid_busy", busy, 1);
         #2 rst = 1'b0;
         #1;
         check("async_tx", tx, 1);
         check("async_busy", busy, 0);
         check("async_done", frame_done, 0);
         check("async_ren", fifo_r_en, 0);
      end else begin
         rst = 1'b0;
      end
      void'(exp_q.pop_front());
      @(negedge clk);
      c0 = ren_cnt;
      push_byte(8'h3C);
      repeat (2) begin
         @(negedge clk);
         check("hold_ren", fifo_r_en, 0);
         check("hold_tx", tx, 1);
      end
      check("hold_ren_cnt", ren_cnt - c0, 0);
      @(posedge clk); #1 rst = 1'b1;
      check_frames(1);
      check("fifo_drained", rd_ptr, wr_ptr);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
